// File: rtl/small_buffer_job_sched_pkg.sv
// Shared types and sizing for the small-buffer job scheduler.
// Depth defaults follow the small-buffer depth macros so both blocks stay in step.
`ifndef SMALL_BUF_DEPTH
`define SMALL_BUF_DEPTH 256
`endif
`ifndef SMALL_BUF_DEPTH_LOG2
`define SMALL_BUF_DEPTH_LOG2 8
`endif

package small_buffer_job_sched_pkg;

  localparam int SB_DEPTH = `SMALL_BUF_DEPTH;
  localparam int SB_CNT_W = `SMALL_BUF_DEPTH_LOG2;

  localparam int NREQ    = 2;
  localparam int BEAT_W  = 256;
  localparam int MODE_W  = 2;
  localparam int LINES_W = 11;
  localparam int EXP_W   = 8;

  // Buffer datapath mode encoding
  localparam logic [MODE_W-1:0] MODE_PASS    = 2'd0;
  localparam logic [MODE_W-1:0] MODE_MUL     = 2'd1;
  localparam logic [MODE_W-1:0] MODE_MAXEXP  = 2'd2;
  localparam logic [MODE_W-1:0] MODE_MUL_MAX = 2'd3;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FILL     = 2'd1,
    WAIT_EXP = 2'd2,
    RESP     = 2'd3
  } sched_state_t;

endpackage

// File: rtl/small_buffer_job_sched_if.sv
// Bundle of request, data, buffer, response and status signals around the scheduler.
// slave is the scheduler's view; master is the surrounding requesters/buffer/consumer.
interface small_buffer_job_sched_if;
  import small_buffer_job_sched_pkg::*;

  logic [NREQ-1:0]         req_vld;
  logic [NREQ-1:0]         req_ready;
  logic [NREQ*MODE_W-1:0]  req_mode;
  logic [NREQ*LINES_W-1:0] req_lines_m1;
  logic [NREQ*BEAT_W-1:0]  dat_in;
  logic [NREQ-1:0]         dat_vld;
  logic [NREQ-1:0]         dat_ready;
  logic [BEAT_W-1:0]       buf_data;
  logic                    buf_vld;
  logic                    buf_ready;
  logic [MODE_W-1:0]       buf_mode;
  logic [LINES_W-1:0]      buf_lines_m1;
  logic [EXP_W-1:0]        buf_exp;
  logic                    buf_exp_vld;
  logic                    rsp_vld;
  logic                    rsp_ready;
  logic                    rsp_id;
  logic [EXP_W-1:0]        rsp_exp;
  logic                    busy;
  logic                    err_gap;
  logic                    err_spurious;

  modport slave (
    input  req_vld, req_mode, req_lines_m1, dat_in, dat_vld, buf_ready,
           buf_exp, buf_exp_vld, rsp_ready,
    output req_ready, dat_ready, buf_data, buf_vld, buf_mode, buf_lines_m1,
           rsp_vld, rsp_id, rsp_exp, busy, err_gap, err_spurious
  );

  modport master (
    output req_vld, req_mode, req_lines_m1, dat_in, dat_vld, buf_ready,
           buf_exp, buf_exp_vld, rsp_ready,
    input  req_ready, dat_ready, buf_data, buf_vld, buf_mode, buf_lines_m1,
           rsp_vld, rsp_id, rsp_exp, busy, err_gap, err_spurious
  );

endinterface

// File: rtl/small_buffer_job_sched_rr_arb2.sv
// Two-input round-robin arbiter, combinational; ptr selects the winner on a tie.
// The pointer register is owned by the caller, en gates all grants.
module rr_arb2 (
  input  logic [1:0] i_req,
  input  logic       i_ptr,
  input  logic       i_en,
  output logic [1:0] o_gnt
);

  assign o_gnt[0] = i_en & i_req[0] & (~i_req[1] | ~i_ptr);
  assign o_gnt[1] = i_en & i_req[1] & (~i_req[0] |  i_ptr);

endmodule

// File: rtl/small_buffer_job_sched.sv
// Locks onto one requester, streams one buffer fill, returns the max exponent with the ID.
// Grant->first beat 1 cycle, exp pulse->rsp_vld 1 cycle; buf_ready/rsp_ready stall it.
module small_buffer_job_sched
  import small_buffer_job_sched_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  parameter int CNT_W = SB_CNT_W
) (
  input logic clk,
  input logic rst,
  small_buffer_job_sched_if.slave bus
);

  sched_state_t       r_state;
  logic               r_gid;
  logic               r_rr;
  logic [CNT_W-1:0]   r_cnt;
  logic [MODE_W-1:0]  r_mode;
  logic [LINES_W-1:0] r_lines;
  logic [EXP_W-1:0]   r_exp;
  logic               r_err_gap;
  logic               r_err_spur;

  logic [1:0]         w_gnt;
  logic               w_idle;
  logic               w_fill;
  logic               w_sel_vld;
  logic               w_buf_vld;
  logic               w_xfer;
  logic               w_last;
  logic               w_gap;

  assign w_idle = (r_state == IDLE);
  assign w_fill = (r_state == FILL);

  // No grants while reset is asserted so req_ready reads as its reset value.
  rr_arb2 u_arb (
    .i_req (bus.req_vld),
    .i_ptr (r_rr),
    .i_en  (w_idle & ~rst),
    .o_gnt (w_gnt)
  );

  assign w_sel_vld = r_gid ? bus.dat_vld[1] : bus.dat_vld[0];
  assign w_buf_vld = w_fill & w_sel_vld;
  assign w_xfer    = w_buf_vld & bus.buf_ready;
  assign w_last    = (r_cnt == CNT_W'(DEPTH - 1));
  // A bubble only matters once the stream has started and the buffer is asking for data.
  assign w_gap     = w_fill & ~w_sel_vld & bus.buf_ready & (r_cnt != '0);

  assign bus.req_ready    = w_gnt;
  assign bus.buf_vld      = w_buf_vld;
  assign bus.buf_data     = !w_fill ? '0 :
                            (r_gid ? bus.dat_in[2*BEAT_W-1:BEAT_W] : bus.dat_in[BEAT_W-1:0]);
  assign bus.dat_ready    = !w_fill ? 2'b00 :
                            (r_gid ? {bus.buf_ready, 1'b0} : {1'b0, bus.buf_ready});
  assign bus.buf_mode     = r_mode;
  assign bus.buf_lines_m1 = r_lines;
  assign bus.rsp_vld      = (r_state == RESP);
  assign bus.rsp_id       = r_gid;
  assign bus.rsp_exp      = r_exp;
  assign bus.busy         = ~w_idle;
  assign bus.err_gap      = r_err_gap;
  assign bus.err_spurious = r_err_spur;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_gid      <= 1'b0;
      r_rr       <= 1'b0;
      r_cnt      <= '0;
      r_mode     <= '0;
      r_lines    <= '0;
      r_exp      <= '0;
      r_err_gap  <= 1'b0;
      r_err_spur <= 1'b0;
    end else begin
      if (bus.buf_exp_vld && (r_state != WAIT_EXP)) begin
        r_err_spur <= 1'b1;
      end
      case (r_state)
        IDLE: begin
          if (|w_gnt) begin
            r_gid   <= w_gnt[1];
            r_mode  <= w_gnt[1] ? bus.req_mode[2*MODE_W-1:MODE_W] : bus.req_mode[MODE_W-1:0];
            r_lines <= w_gnt[1] ? bus.req_lines_m1[2*LINES_W-1:LINES_W]
                                : bus.req_lines_m1[LINES_W-1:0];
            r_cnt   <= '0;
            r_state <= FILL;
          end
        end
        FILL: begin
          if (w_gap) begin
            r_err_gap <= 1'b1;
          end
          if (w_xfer) begin
            r_cnt <= r_cnt + CNT_W'(1);
            if (w_last) begin
              r_state <= WAIT_EXP;
            end
          end
        end
        WAIT_EXP: begin
          if (bus.buf_exp_vld) begin
            r_exp   <= bus.buf_exp;
            r_state <= RESP;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            r_rr    <= ~r_gid;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_small_buffer_job_sched.sv
// Directed bench for small_buffer_job_sched: the bench plays requesters, buffer and consumer.
module tb_small_buffer_job_sched;
  import small_buffer_job_sched_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  small_buffer_job_sched_if sb_if ();

  small_buffer_job_sched #(.DEPTH(256), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (sb_if)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [255:0] beat_word(input int id, input int n);
    logic [31:0] w;
    w = {8'(8'hA0 + id), 8'h5A, 16'(n)};
    return {8{w}};
  endfunction

  task automatic clear_inputs();
    sb_if.req_vld      = 2'b00;
    sb_if.req_mode     = '0;
    sb_if.req_lines_m1 = '0;
    sb_if.dat_in       = '0;
    sb_if.dat_vld      = 2'b00;
    sb_if.buf_ready    = 1'b0;
    sb_if.buf_exp      = '0;
    sb_if.buf_exp_vld  = 1'b0;
    sb_if.rsp_ready    = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Called just after a negedge while the DUT is in IDLE; the grant happens at the next posedge.
  task automatic grant(input logic [1:0] mask, input int m0, input int m1,
                       input int l0, input int l1, output logic [1:0] seen);
    sb_if.req_vld      = mask;
    sb_if.req_mode     = {2'(m1), 2'(m0)};
    sb_if.req_lines_m1 = {11'(l1), 11'(l0)};
    #1;
    seen = sb_if.req_ready;
  endtask

  // Streams beats for requester id; bad counts per-cycle stream mismatches, tail_bad flags
  // a DUT that still accepts data after DEPTH beats.
  task automatic fill(input int id, input int gap_at, input int stall_at, input int stall_len,
                      input int spur_at, input int abort_at,
                      output int beats, output int bad, output int tail_bad);
    int cyc, stalls;
    bit gap_done, spur_done, v, r;
    logic [255:0] exp_w;
    beats = 0; bad = 0; tail_bad = 0; cyc = 0; stalls = 0;
    gap_done = 1'b0; spur_done = 1'b0;
    while (beats < 256 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (beats == abort_at) return;
      v = !(beats == gap_at && !gap_done);
      r = !(beats == stall_at && stalls < stall_len);
      exp_w = beat_word(id, beats);
      sb_if.dat_vld     = v ? 2'(1 << id) : 2'b00;
      sb_if.dat_in      = (id == 1) ? {exp_w, ~exp_w} : {~exp_w, exp_w};
      sb_if.buf_ready   = r;
      sb_if.buf_exp     = 8'hEE;
      sb_if.buf_exp_vld = (beats == spur_at && !spur_done);
      #1;
      if (sb_if.buf_vld !== v || sb_if.dat_ready !== (r ? 2'(1 << id) : 2'b00) ||
          sb_if.req_ready !== 2'b00 || (v && sb_if.buf_data !== exp_w)) bad++;
      if (!v) gap_done = 1'b1;
      if (!r) stalls++;
      if (sb_if.buf_exp_vld) spur_done = 1'b1;
      if (v && r) beats++;
    end
    if (beats == 256) begin
      @(negedge clk);
      sb_if.dat_vld     = 2'(1 << id);
      sb_if.buf_ready   = 1'b1;
      sb_if.buf_exp_vld = 1'b0;
      #1;
      if (sb_if.buf_vld !== 1'b0 || sb_if.dat_ready !== 2'b00) tail_bad = 1;
    end
    sb_if.dat_vld     = 2'b00;
    sb_if.buf_ready   = 1'b0;
    sb_if.buf_exp_vld = 1'b0;
  endtask

  task automatic pulse_exp(input logic [7:0] val);
    @(negedge clk);
    sb_if.buf_exp     = val;
    sb_if.buf_exp_vld = 1'b1;
    @(negedge clk);
    sb_if.buf_exp_vld = 1'b0;
    #1;
  endtask

  task automatic handshake();
    sb_if.rsp_ready = 1'b1;
    @(negedge clk);
    sb_if.rsp_ready = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    sb_if.req_vld = 2'b11;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (sb_if.req_ready !== 2'b00) begin
      errors++; $display("FAIL reset_req_ready got %b exp 00", sb_if.req_ready);
    end
    checks++;
    if ({sb_if.busy, sb_if.rsp_vld, sb_if.buf_vld, sb_if.dat_ready} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl got busy=%b rsp_vld=%b buf_vld=%b dat_ready=%b exp 0",
                         sb_if.busy, sb_if.rsp_vld, sb_if.buf_vld, sb_if.dat_ready);
    end
    checks++;
    if ({sb_if.buf_mode, sb_if.buf_lines_m1, sb_if.rsp_id, sb_if.rsp_exp} !== 22'b0) begin
      errors++; $display("FAIL reset_cfg got mode=%h lines=%h id=%b exp=%h exp all 0",
                         sb_if.buf_mode, sb_if.buf_lines_m1, sb_if.rsp_id, sb_if.rsp_exp);
    end
    checks++;
    if ({sb_if.err_gap, sb_if.err_spurious} !== 2'b00) begin
      errors++; $display("FAIL reset_err got %b%b exp 00", sb_if.err_gap, sb_if.err_spurious);
    end
    sb_if.req_vld = 2'b00;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_job();
    logic [1:0] seen;
    int beats, bad, tail;
    grant(2'b01, 1, 0, 3, 0, seen);
    checks++;
    if (seen !== 2'b01) begin errors++; $display("FAIL single_grant got %b exp 01", seen); end
    @(posedge clk); #1;
    sb_if.req_vld = 2'b00;
    checks++;
    if (sb_if.busy !== 1'b1 || sb_if.buf_mode !== 2'd1 || sb_if.buf_lines_m1 !== 11'd3) begin
      errors++; $display("FAIL single_cfg got busy=%b mode=%0d lines=%0d exp 1/1/3",
                         sb_if.busy, sb_if.buf_mode, sb_if.buf_lines_m1);
    end
    fill(0, -1, -1, 0, -1, -1, beats, bad, tail);
    checks++;
    if (beats !== 256 || bad !== 0 || tail !== 0) begin
      errors++; $display("FAIL single_fill got beats=%0d bad=%0d tail=%0d exp 256/0/0",
                         beats, bad, tail);
    end
    checks++;
    if (sb_if.buf_mode !== 2'd1 || sb_if.buf_lines_m1 !== 11'd3) begin
      errors++; $display("FAIL single_cfg_hold got mode=%0d lines=%0d exp 1/3",
                         sb_if.buf_mode, sb_if.buf_lines_m1);
    end
    pulse_exp(8'h7F);
    checks++;
    if (sb_if.rsp_vld !== 1'b1 || sb_if.rsp_id !== 1'b0 || sb_if.rsp_exp !== 8'h7F) begin
      errors++; $display("FAIL single_rsp got vld=%b id=%b exp=%h exp 1/0/7f",
                         sb_if.rsp_vld, sb_if.rsp_id, sb_if.rsp_exp);
    end
    handshake();
    checks++;
    if (sb_if.rsp_vld !== 1'b0 || sb_if.busy !== 1'b0 || sb_if.err_gap !== 1'b0) begin
      errors++; $display("FAIL single_done got rsp_vld=%b busy=%b err_gap=%b exp 0/0/0",
                         sb_if.rsp_vld, sb_if.busy, sb_if.err_gap);
    end
  endtask

  task automatic test_tie_fairness();
    logic [1:0] seen;
    int beats, bad, tail, eid;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      eid = k % 2;
      grant(2'b11, 2, 3, 5, 11'h7FF, seen);
      checks++;
      if (seen !== 2'(1 << eid)) begin
        errors++; $display("FAIL tie_grant job %0d got %b exp %b", k, seen, 2'(1 << eid));
      end
      @(posedge clk); #1;
      checks++;
      if (sb_if.buf_mode !== ((eid == 1) ? 2'd3 : 2'd2) ||
          sb_if.buf_lines_m1 !== ((eid == 1) ? 11'h7FF : 11'd5)) begin
        errors++; $display("FAIL tie_cfg job %0d got mode=%0d lines=%h", k,
                           sb_if.buf_mode, sb_if.buf_lines_m1);
      end
      fill(eid, -1, -1, 0, -1, -1, beats, bad, tail);
      checks++;
      if (beats !== 256 || bad !== 0 || tail !== 0) begin
        errors++; $display("FAIL tie_fill job %0d got beats=%0d bad=%0d tail=%0d exp 256/0/0",
                           k, beats, bad, tail);
      end
      pulse_exp(8'(8'h10 + k));
      checks++;
      if (sb_if.rsp_vld !== 1'b1 || sb_if.rsp_id !== 1'(eid) || sb_if.rsp_exp !== 8'(8'h10 + k)) begin
        errors++; $display("FAIL tie_rsp job %0d got vld=%b id=%b exp=%h exp 1/%0d/%h", k,
                           sb_if.rsp_vld, sb_if.rsp_id, sb_if.rsp_exp, eid, 8'(8'h10 + k));
      end
      handshake();
    end
    sb_if.req_vld = 2'b00;
  endtask

  task automatic test_backpressure();
    logic [1:0] seen;
    int beats, bad, tail, hold_bad;
    grant(2'b10, 0, 2, 0, 100, seen);
    @(posedge clk); #1;
    sb_if.req_vld = 2'b00;
    fill(1, -1, 60, 10, -1, -1, beats, bad, tail);
    checks++;
    if (seen !== 2'b10 || beats !== 256 || bad !== 0 || tail !== 0 || sb_if.err_gap !== 1'b0) begin
      errors++; $display("FAIL bp_fill got gnt=%b beats=%0d bad=%0d tail=%0d err_gap=%b",
                         seen, beats, bad, tail, sb_if.err_gap);
    end
    pulse_exp(8'h33);
    sb_if.req_vld = 2'b01;
    hold_bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (sb_if.rsp_vld !== 1'b1 || sb_if.rsp_id !== 1'b1 || sb_if.rsp_exp !== 8'h33 ||
          sb_if.req_ready !== 2'b00 || sb_if.busy !== 1'b1) hold_bad++;
      @(negedge clk); #1;
    end
    checks++;
    if (hold_bad !== 0) begin errors++; $display("FAIL bp_rsp_hold got %0d bad cycles exp 0", hold_bad); end
    handshake();
    checks++;
    if (sb_if.rsp_vld !== 1'b0 || sb_if.req_ready !== 2'b01) begin
      errors++; $display("FAIL bp_release got rsp_vld=%b req_ready=%b exp 0/01",
                         sb_if.rsp_vld, sb_if.req_ready);
    end
    sb_if.req_vld = 2'b00;
    @(negedge clk);
  endtask

  task automatic test_gap();
    logic [1:0] seen;
    int beats, bad, tail;
    grant(2'b01, 0, 0, 7, 0, seen);
    @(posedge clk); #1;
    sb_if.req_vld = 2'b00;
    fill(0, 100, -1, 0, -1, -1, beats, bad, tail);
    checks++;
    if (sb_if.err_gap !== 1'b1 || beats !== 256 || bad !== 0 || tail !== 0) begin
      errors++; $display("FAIL gap_fill got err_gap=%b beats=%0d bad=%0d tail=%0d exp 1/256/0/0",
                         sb_if.err_gap, beats, bad, tail);
    end
    pulse_exp(8'h01);
    handshake();
    checks++;
    if (sb_if.err_gap !== 1'b1 || sb_if.busy !== 1'b0) begin
      errors++; $display("FAIL gap_sticky got err_gap=%b busy=%b exp 1/0", sb_if.err_gap, sb_if.busy);
    end
  endtask

  task automatic test_spurious();
    logic [1:0] seen;
    int beats, bad, tail;
    checks++;
    if (sb_if.err_spurious !== 1'b0) begin
      errors++; $display("FAIL spur_pre got %b exp 0", sb_if.err_spurious);
    end
    grant(2'b01, 3, 0, 1, 0, seen);
    @(posedge clk); #1;
    sb_if.req_vld = 2'b00;
    fill(0, -1, -1, 0, 30, -1, beats, bad, tail);
    checks++;
    if (sb_if.err_spurious !== 1'b1 || beats !== 256 || bad !== 0 || tail !== 0) begin
      errors++; $display("FAIL spur_fill got err_spur=%b beats=%0d bad=%0d tail=%0d exp 1/256/0/0",
                         sb_if.err_spurious, beats, bad, tail);
    end
    pulse_exp(8'h42);
    checks++;
    if (sb_if.rsp_vld !== 1'b1 || sb_if.rsp_exp !== 8'h42) begin
      errors++; $display("FAIL spur_capture got vld=%b exp=%h exp 1/42", sb_if.rsp_vld, sb_if.rsp_exp);
    end
    handshake();
  endtask

  task automatic test_reset_mid_fill();
    logic [1:0] seen;
    int beats, bad, tail, idle_bad;
    grant(2'b10, 0, 2, 0, 9, seen);
    @(posedge clk); #1;
    sb_if.req_vld = 2'b00;
    fill(1, -1, -1, 0, -1, 50, beats, bad, tail);
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL rst_prefill got bad=%0d exp 0", bad); end
    rst = 1'b1;
    @(negedge clk); #1;
    checks++;
    if ({sb_if.busy, sb_if.buf_vld, sb_if.dat_ready, sb_if.rsp_vld,
         sb_if.err_gap, sb_if.err_spurious} !== 7'b0 ||
        sb_if.buf_mode !== 2'd0 || sb_if.buf_lines_m1 !== 11'd0) begin
      errors++; $display("FAIL rst_mid got busy=%b buf_vld=%b dat_rdy=%b rsp=%b eg=%b es=%b mode=%0d lines=%0d",
                         sb_if.busy, sb_if.buf_vld, sb_if.dat_ready, sb_if.rsp_vld, sb_if.err_gap,
                         sb_if.err_spurious, sb_if.buf_mode, sb_if.buf_lines_m1);
    end
    rst = 1'b0;
    clear_inputs();
    idle_bad = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      if (sb_if.rsp_vld !== 1'b0 || sb_if.busy !== 1'b0) idle_bad++;
    end
    checks++;
    if (idle_bad !== 0) begin errors++; $display("FAIL rst_no_rsp got %0d bad cycles exp 0", idle_bad); end
    grant(2'b01, 1, 0, 2, 0, seen);
    @(posedge clk); #1;
    sb_if.req_vld = 2'b00;
    fill(0, -1, -1, 0, -1, -1, beats, bad, tail);
    checks++;
    if (seen !== 2'b01 || beats !== 256 || bad !== 0 || tail !== 0) begin
      errors++; $display("FAIL rst_fresh_fill got gnt=%b beats=%0d bad=%0d tail=%0d",
                         seen, beats, bad, tail);
    end
    pulse_exp(8'h5A);
    checks++;
    if (sb_if.rsp_vld !== 1'b1 || sb_if.rsp_id !== 1'b0 || sb_if.rsp_exp !== 8'h5A ||
        sb_if.err_gap !== 1'b0 || sb_if.err_spurious !== 1'b0) begin
      errors++; $display("FAIL rst_fresh_rsp got vld=%b id=%b exp=%h eg=%b es=%b exp 1/0/5a/0/0",
                         sb_if.rsp_vld, sb_if.rsp_id, sb_if.rsp_exp, sb_if.err_gap, sb_if.err_spurious);
    end
    handshake();
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_single_job();
    test_tie_fairness();
    test_backpressure();
    test_gap();
    test_spurious();
    test_reset_mid_fill();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/small_buffer_job_sched.md
# small_buffer_job_sched

Job scheduler in front of the small-buffer multiply/max-exponent datapath. It arbitrates round-robin between two requesters and locks onto one job at a time. For that job it drives the buffer's mode and line-count configuration, forwards exactly one buffer fill of 256-bit beats, and captures the single-cycle max-exponent pulse. It returns the captured exponent, tagged with the requester ID, on a valid/ready response port.

## Interface
- `DEPTH`, 256: beats per job; equals the buffer depth.
- `CNT_W`, 8: beat-counter width, log2(`DEPTH`).
- `clk`  in  1  clock
- `rst`  in  1  synchronous, active-high reset
- `req_vld`  in  2  job request, one bit per requester
- `req_ready`  out  2  job accepted, one-hot or zero
- `req_mode`  in  4  {req1, req0} 2-bit mode
- `req_lines_m1`  in  22  {req1, req0} 11-bit line-count-minus-one per node
- `dat_in`  in  512  {req1, req0} 256-bit data beats
- `dat_vld`  in  2  data valid per requester
- `dat_ready`  out  2  data ready per requester
- `buf_data`  out  256  beat to buffer
- `buf_vld`  out  1  beat valid to buffer
- `buf_ready`  in  1  buffer input ready
- `buf_mode`  out  2  configured mode
- `buf_lines_m1`  out  11  configured lines-minus-one
- `buf_exp`  in  8  max exponent from buffer
- `buf_exp_vld`  in  1  single-cycle exponent pulse
- `rsp_vld`  out  1  response valid
- `rsp_ready`  in  1  response consumer ready
- `rsp_id`  out  1  requester ID of the job
- `rsp_exp`  out  8  captured exponent
- `busy`  out  1  state ≠ IDLE
- `err_gap`  out  1  sticky: `dat_vld` dropped mid-fill
- `err_spurious`  out  1  sticky: `buf_exp_vld` seen outside WAIT_EXP

## Operation
- State machine: IDLE → FILL → WAIT_EXP → RESP → IDLE.
- **IDLE**
  - With one `req_vld` set, grant that requester.
  - With both set, grant the requester selected by the round-robin pointer `rr`.
  - `req_ready[g]` is combinational in the grant cycle.
  - On the grant, latch `gid` = g, the mode and lines_m1 into `buf_mode`/`buf_lines_m1`, clear the beat counter, go to FILL.
- **FILL**
  - `buf_data` = `dat_in[gid]`.
  - `buf_vld` = `dat_vld[gid]`.
  - `dat_ready[gid]` = `buf_ready`.
  - The non-granted `dat_ready` is 0.
  - A beat transfers when `buf_vld` & `buf_ready`; the counter increments on each transfer.
  - On the transfer with counter = `DEPTH`-1, go to WAIT_EXP.
  - The buffer needs a gapless stream: if `dat_vld[gid]`=0 while `buf_ready`=1 after the first beat of a fill, set `err_gap` and keep counting only real transfers.
- **WAIT_EXP**
  - `buf_vld`=0.
  - On `buf_exp_vld`, capture `buf_exp` into `rsp_exp`, go to RESP.
- **RESP**
  - `rsp_vld`=1; hold `rsp_id`/`rsp_exp` stable until `rsp_ready`.
  - On the handshake, set `rr` = ~`gid` and go to IDLE.
- `buf_mode`/`buf_lines_m1` hold from the grant until the next grant; they never change mid-job.
- `buf_exp_vld` in any state except WAIT_EXP sets `err_spurious` and is otherwise ignored.
- Error flags clear only on `rst`.

## Timing
- Reset values:
  - state IDLE; `rr`=0, so requester 0 wins the first tie.
  - `req_ready`, `dat_ready`, `buf_vld`, `rsp_vld`, `busy`, `err_*` = 0.
  - `buf_mode`, `buf_lines_m1`, `rsp_id`, `rsp_exp`, counter = 0.
- Grant to first possible beat: 1 cycle, because FILL starts the cycle after the grant.
- Exponent pulse to `rsp_vld`: 1 cycle.
- RESP handshake to next grant: 1 cycle, because IDLE is visited for one cycle minimum.
- `rst` asserted mid-job aborts it: no response, all outputs return to reset values next cycle, any partial fill is discarded.
- Request and response never overlap; at most one job is in flight.

## Structure
- Shared package:
  - state enum {IDLE, FILL, WAIT_EXP, RESP}
  - `DEPTH`/`CNT_W` defaults, tied to the small-buffer depth macros
  - mode encoding constants
- Sub-module `rr_arb2`: 2-input round-robin arbiter.
  - Inputs: req[1:0], ptr, en.
  - Output: one-hot gnt.
  - Purely combinational; the pointer register lives in the parent.

## Test plan
1. Single job: req0 with mode=1, lines_m1=3; 256 gapless beats; buffer pulses exp=0x7F → `rsp_vld`=1, `rsp_id`=0, `rsp_exp`=0x7F; `buf_mode`=1, `buf_lines_m1`=3 throughout.
2. Tie and fairness: both requesters valid from reset → jobs granted in order 0, 1, 0, 1; `rsp_id` sequence matches.
3. Backpressure:
   - `buf_ready` low for 10 cycles mid-fill → exactly 256 transfers, `err_gap`=0.
   - `rsp_ready` low 5 cycles → `rsp_*` stable, no new grant.
4. Gap: drop `dat_vld` for 1 cycle at beat 100 with `buf_ready`=1 → `err_gap`=1 (sticky), still 256 transfers before WAIT_EXP.
5. Spurious pulse: `buf_exp_vld` during FILL → `err_spurious`=1, state unchanged; a later pulse in WAIT_EXP is captured normally.
6. Reset mid-FILL at beat 50 → next cycle IDLE, all outputs zero, no response; a fresh job then completes normally.
